// File: rtl/fp32_to_int32_seq.sv
// FP32 to signed INT32 converter, multi-cycle.
// Iterative right-shift denormalizer with RNE/RTZ rounding.
module fp32_to_int32_seq #(
  parameter int STEP = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] a,
  input  logic        rnd_mode,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] res,
  output logic        invalid,
  output logic        inexact
);

  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    SHIFT = 2'd1,
    ROUND = 2'd2,
    DONE  = 2'd3
  } state_t;

  state_t      state_q, state_d;
  logic        s_q, s_d;
  logic        rtz_q, rtz_d;
  logic        nan_q, nan_d;
  logic        inf_q, inf_d;
  logic        zero_q, zero_d;
  logic        ovf_q, ovf_d;
  logic        min_q, min_d;
  logic        fnz_q, fnz_d;
  logic [31:0] man_q, man_d;
  logic [4:0]  n_q, n_d;
  logic        g_q, g_d;
  logic        st_q, st_d;
  logic [31:0] res_q, res_d;
  logic        inv_q, inv_d;
  logic        inx_q, inx_d;

  logic [7:0]  e;
  logic [22:0] f;
  logic [23:0] m;
  logic [2:0]  lsh;
  logic [7:0]  dn;
  logic [4:0]  n_init;
  logic [31:0] m_init;

  logic [31:0] sm;
  logic        sg;
  logic        ss;
  logic [4:0]  sn;

  logic        inc;
  logic [31:0] q2;
  logic [31:0] qs;

  assign in_ready  = (state_q == IDLE);
  assign out_valid = (state_q == DONE);
  assign res       = res_q;
  assign invalid   = inv_q;
  assign inexact   = inx_q;

  // Operand unpack, denormalizer step and rounding datapath
  always_comb begin
    e   = a[30:23];
    f   = a[22:0];
    m   = {1'b1, f};
    lsh = e[2:0] - 3'd6;
    dn  = 8'd150 - e;
    if (e >= 8'd150 && e <= 8'd157) begin
      m_init = {8'b0, m} << lsh;
    end else begin
      m_init = {8'b0, m};
    end
    if (e >= 8'd1 && e <= 8'd149) begin
      n_init = (dn > 8'd26) ? 5'd26 : dn[4:0];
    end else begin
      n_init = 5'd0;
    end

    sm = man_q;
    sg = g_q;
    ss = st_q;
    sn = n_q;
    for (int i = 0; i < STEP; i++) begin
      if (sn != 5'd0) begin
        ss = ss | sg;
        sg = sm[0];
        sm = sm >> 1;
        sn = sn - 5'd1;
      end
    end

    inc = !rtz_q && g_q && (st_q || man_q[0]);
    q2  = man_q + {31'b0, inc};
    qs  = s_q ? (32'd0 - q2) : q2;
  end

  // Next-state and register-update logic
  always_comb begin
    state_d = state_q;
    s_d     = s_q;
    rtz_d   = rtz_q;
    nan_d   = nan_q;
    inf_d   = inf_q;
    zero_d  = zero_q;
    ovf_d   = ovf_q;
    min_d   = min_q;
    fnz_d   = fnz_q;
    man_d   = man_q;
    n_d     = n_q;
    g_d     = g_q;
    st_d    = st_q;
    res_d   = res_q;
    inv_d   = inv_q;
    inx_d   = inx_q;
    unique case (state_q)
      IDLE: begin
        if (in_valid) begin
          s_d     = a[31];
          rtz_d   = rnd_mode;
          nan_d   = (e == 8'd255) && (f != 23'd0);
          inf_d   = (e == 8'd255) && (f == 23'd0);
          zero_d  = (e == 8'd0);
          ovf_d   = (e > 8'd158) ||
                    ((e == 8'd158) &&
                     (!a[31] || f != 23'd0));
          min_d   = (e == 8'd158) && a[31] &&
                    (f == 23'd0);
          fnz_d   = (f != 23'd0);
          man_d   = m_init;
          n_d     = n_init;
          g_d     = 1'b0;
          st_d    = 1'b0;
          state_d = SHIFT;
        end
      end
      SHIFT: begin
        man_d = sm;
        n_d   = sn;
        g_d   = sg;
        st_d  = ss;
        if (sn == 5'd0) state_d = ROUND;
      end
      ROUND: begin
        if (zero_q) begin
          res_d = 32'd0;
          inv_d = 1'b0;
          inx_d = fnz_q;
        end else if (nan_q) begin
          res_d = 32'h7FFF_FFFF;
          inv_d = 1'b1;
          inx_d = 1'b0;
        end else if (inf_q || ovf_q) begin
          res_d = s_q ? 32'h8000_0000 : 32'h7FFF_FFFF;
          inv_d = 1'b1;
          inx_d = 1'b0;
        end else if (min_q) begin
          res_d = 32'h8000_0000;
          inv_d = 1'b0;
          inx_d = 1'b0;
        end else begin
          res_d = qs;
          inv_d = 1'b0;
          inx_d = g_q || st_q;
        end
        state_d = DONE;
      end
      DONE: begin
        if (out_ready) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  // State and datapath registers with synchronous reset
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      s_q     <= 1'b0;
      rtz_q   <= 1'b0;
      nan_q   <= 1'b0;
      inf_q   <= 1'b0;
      zero_q  <= 1'b0;
      ovf_q   <= 1'b0;
      min_q   <= 1'b0;
      fnz_q   <= 1'b0;
      man_q   <= 32'd0;
      n_q     <= 5'd0;
      g_q     <= 1'b0;
      st_q    <= 1'b0;
      res_q   <= 32'd0;
      inv_q   <= 1'b0;
      inx_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      s_q     <= s_d;
      rtz_q   <= rtz_d;
      nan_q   <= nan_d;
      inf_q   <= inf_d;
      zero_q  <= zero_d;
      ovf_q   <= ovf_d;
      min_q   <= min_d;
      fnz_q   <= fnz_d;
      man_q   <= man_d;
      n_q     <= n_d;
      g_q     <= g_d;
      st_q    <= st_d;
      res_q   <= res_d;
      inv_q   <= inv_d;
      inx_q   <= inx_d;
    end
  end

endmodule

// File: tb/tb_fp32_to_int32_seq.sv
// Testbench for fp32_to_int32_seq.
// Scoreboard with a real-arithmetic reference model.
module tb_fp32_to_int32_seq;

  localparam int STEP = 1;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] a;
  logic        rnd_mode;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] res;
  logic        invalid;
  logic        inexact;

  fp32_to_int32_seq #(.STEP(STEP)) dut (
    .clk       (clk),
    .rst       (rst),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .a         (a),
    .rnd_mode  (rnd_mode),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .res       (res),
    .invalid   (invalid),
    .inexact   (inexact)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] res;
    logic        inv;
    logic        inx;
    int          lat;
    int          edge_i;
  } exp_t;

  exp_t sb[$];
  int   n_chk = 0;
  int   n_pass = 0;
  int   cyc = 0;
  int   out_edge = -1;
  int   last_in_edge = -1;
  int   rdy_mode = 0;
  logic prev_valid = 1'b0;

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string nm, input logic [63:0] act,
                     input logic [63:0] expv);
    n_chk++;
    if (act === expv) n_pass++;
    else $display("FAIL %s: got %h expected %h (t=%0t)",
                  nm, act, expv, $time);
  endtask

  // Reference: exact real value, floor, then rounding rule.
  function automatic exp_t model(input logic [31:0] x,
                                 input logic rm);
    exp_t   r;
    logic   s;
    int     e;
    int     fi;
    int     n;
    real    v;
    real    ip;
    real    fr;
    longint mag;
    longint l;
    s  = x[31];
    e  = int'(x[30:23]);
    fi = int'(x[22:0]);
    r.res = 32'd0;
    r.inv = 1'b0;
    r.inx = 1'b0;
    r.lat = -1;
    r.edge_i = 0;
    if (e == 255) begin
      r.inv = 1'b1;
      r.res = (fi != 0 || !s) ? 32'h7FFF_FFFF : 32'h8000_0000;
      return r;
    end
    if (e == 0) begin
      r.inx = (fi != 0);
      return r;
    end
    if (e <= 149) begin
      n = (150 - e > 26) ? 26 : 150 - e;
      r.lat = (n + STEP - 1) / STEP + 2;
    end
    v = (1.0 + real'(fi) / 8388608.0) * $pow(2.0, real'(e - 127));
    if (v >= 2147483648.0) begin
      if (s && v == 2147483648.0) begin
        r.res = 32'h8000_0000;
      end else begin
        r.inv = 1'b1;
        r.res = s ? 32'h8000_0000 : 32'h7FFF_FFFF;
      end
      return r;
    end
    ip  = $floor(v);
    fr  = v - ip;
    mag = longint'(ip);
    r.inx = (fr != 0.0);
    if (!rm && (fr > 0.5 || (fr == 0.5 && mag[0]))) mag++;
    l = s ? -mag : mag;
    r.res = l[31:0];
    return r;
  endfunction

  task automatic send(input logic [31:0] x, input logic rm);
    exp_t ex;
    int   k;
    in_valid = 1'b1;
    a        = x;
    rnd_mode = rm;
    k = 0;
    @(negedge clk);
    while (!in_ready && k < 200) begin
      k++;
      @(negedge clk);
    end
    if (!in_ready) begin
      chk("accept_timeout", in_ready, 1);
    end else begin
      ex = model(x, rm);
      ex.edge_i = cyc + 1;
      last_in_edge = cyc + 1;
      sb.push_back(ex);
    end
    @(posedge clk);
    #1;
    in_valid = 1'b0;
    a        = $urandom;
    rnd_mode = 1'($urandom);
  endtask

  task automatic drain();
    int k;
    k = 0;
    while (sb.size() != 0 && k < 1000) begin
      @(posedge clk);
      k++;
    end
    chk("drain", sb.size(), 0);
    @(posedge clk);
    #1;
  endtask

  // out_ready driver: 0 always, 1 random, 3 manual
  initial begin
    out_ready = 1'b1;
    forever begin
      @(posedge clk);
      #1;
      if (rdy_mode == 0) out_ready = 1'b1;
      else if (rdy_mode == 1) out_ready = ($urandom % 3) != 0;
    end
  end

  // Monitor: compare presented output with scoreboard head
  initial begin
    forever begin
      @(negedge clk);
      if (rst) begin
        prev_valid = 1'b0;
      end else begin
        if (out_valid) begin
          if (sb.size() == 0) begin
            chk("unexpected_out", out_valid, 0);
          end else begin
            if (!prev_valid && sb[0].lat >= 0)
              chk("latency", cyc + 1 - sb[0].edge_i, sb[0].lat);
            chk("res", res, sb[0].res);
            chk("invalid", invalid, sb[0].inv);
            chk("inexact", inexact, sb[0].inx);
            chk("in_ready_busy", in_ready, 0);
            if (out_ready) begin
              out_edge = cyc + 1;
              void'(sb.pop_front());
            end
          end
        end
        prev_valid = out_valid && !out_ready;
      end
    end
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] dir_a [12] = '{
    32'h40490FDB, 32'h3FC00000, 32'h40200000, 32'h40200000,
    32'hBFC00000, 32'hCF000000, 32'h4F000000, 32'h4B800001,
    32'h7FC00000, 32'hFF800000, 32'h00000001, 32'h3F000000
  };
  logic dir_rm [12] = '{
    1'b0, 1'b0, 1'b0, 1'b1, 1'b0, 1'b0,
    1'b0, 1'b0, 1'b0, 1'b0, 1'b0, 1'b0
  };

  initial begin
    logic [31:0] x;
    logic [7:0]  ex;
    logic [22:0] fx;
    int          k;
    rst      = 1'b1;
    in_valid = 1'b0;
    a        = 32'd0;
    rnd_mode = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    chk("rst_out_valid", out_valid, 0);
    chk("rst_res", res, 0);
    chk("rst_invalid", invalid, 0);
    chk("rst_inexact", inexact, 0);
    chk("rst_in_ready", in_ready, 1);
    @(posedge clk);
    #1;

    for (int i = 0; i < 12; i++) send(dir_a[i], dir_rm[i]);
    drain();

    rdy_mode = 1;
    for (int i = 0; i < 150; i++) begin
      k = int'($urandom % 8);
      if (k == 0) ex = 8'd0;
      else if (k == 1) ex = 8'd255;
      else ex = 8'(118 + ($urandom % 44));
      fx = ($urandom % 4 == 0) ? 23'd0 : 23'($urandom);
      x = {1'($urandom), ex, fx};
      send(x, 1'($urandom));
    end
    drain();

    @(negedge clk);
    rdy_mode = 3;
    out_ready = 1'b0;
    @(posedge clk);
    #1;
    send(32'h3FC00000, 1'b0);
    k = 0;
    while (!out_valid && k < 100) begin
      @(negedge clk);
      k++;
    end
    chk("bp_valid_seen", out_valid, 1);
    for (int i = 0; i < 5; i++) begin
      @(posedge clk);
      #1;
      in_valid = 1'b1;
      a        = 32'h40200000;
      rnd_mode = 1'b1;
      @(negedge clk);
      chk("bp_in_ready_low", in_ready, 0);
    end
    @(posedge clk);
    #1;
    out_ready = 1'b1;
    send(32'h40200000, 1'b1);
    rdy_mode = 0;
    chk("accept_after_out", last_in_edge, out_edge + 1);
    drain();

    send(32'h00FFFFFF, 1'b0);
    repeat (3) @(posedge clk);
    #1;
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    sb.delete();
    @(negedge clk);
    chk("abort_out_valid", out_valid, 0);
    chk("abort_res", res, 0);
    chk("abort_in_ready", in_ready, 1);
    repeat (40) @(posedge clk);
    #1;
    send(32'hBFC00000, 1'b1);
    drain();

    $display("%0d/%0d checks passed", n_pass, n_chk);
    $finish;
  end

endmodule
